// File: rtl/ec_field_pkg.sv
// Shared types and helpers for the EC field-arithmetic datapath blocks.
package ec_field_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      FIX,
      DONE
   } modred_state_t;

   localparam int DEFAULT_MODULUS = 17;

   // Ceiling log2 for elaboration-time width sizing.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder and subtract the modulus when it fits.
module mod_sub_step
   import ec_field_pkg::*;
#(
   parameter int MOD_W = 8
) (
   input  logic [MOD_W:0]   rem_i,
   input  logic             bit_i,
   input  logic [MOD_W-1:0] mod_i,
   output logic [MOD_W:0]   rem_o
);

   logic [MOD_W+1:0] shifted;
   logic [MOD_W+1:0] mod_ext;

   assign shifted = {rem_i, bit_i};
   assign mod_ext = {2'b00, mod_i};

   // NOTE: every output of a combinational block is assigned on every path,
   // so no latch can be inferred.
   always_comb begin
      if (shifted >= mod_ext) begin
         rem_o = (MOD_W+1)'(shifted - mod_ext);
      end else begin
         rem_o = shifted[MOD_W:0];
      end
   end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential signed modular reducer, one restoring-division bit per clock.
// Define MOD_RUNTIME_EN to take the modulus from port mod_in at acceptance.
module mod_reduce_seq
   import ec_field_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int MOD_W   = 8,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
`ifdef MOD_RUNTIME_EN
   input  logic [MOD_W-1:0]  mod_in,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int CNT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);

   modred_state_t     state_q;
   logic              sign_q;
   logic [DATA_W-1:0] mag_q;
   logic [MOD_W:0]    rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;

   logic [MOD_W-1:0]  mod_val;
   logic [MOD_W:0]    rem_d;
   logic [MOD_W:0]    res_d;
   logic [DATA_W-1:0] mag_neg;

`ifdef MOD_RUNTIME_EN
   logic [MOD_W-1:0]  mod_q;
   assign mod_val = mod_q;
`else
   assign mod_val = MOD_W'(MODULUS);
`endif

   // The most negative input maps to 2**(DATA_W-1), which is exact unsigned.
   assign mag_neg = -in_data;

   mod_sub_step #(
      .MOD_W (MOD_W)
   ) u_step (
      .rem_i (rem_q),
      .bit_i (mag_q[DATA_W-1]),
      .mod_i (mod_val),
      .rem_o (rem_d)
   );

   // Negative inputs fold to M-rem, except exact multiples, which stay 0.
   always_comb begin
      res_d = rem_q;
      if (mod_val == '0) begin
         res_d = '0;
      end else if (sign_q && (rem_q != '0)) begin
         res_d = {1'b0, mod_val} - rem_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MOD_RUNTIME_EN
         mod_q       <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q  <= in_data[DATA_W-1];
                  mag_q   <= in_data[DATA_W-1] ? mag_neg : in_data;
                  rem_q   <= '0;
                  cnt_q   <= CNT_W'(DATA_W - 1);
`ifdef MOD_RUNTIME_EN
                  mod_q   <= mod_in;
`endif
                  state_q <= DIV;
               end
            end
            DIV: begin
               rem_q <= rem_d;
               mag_q <= {mag_q[DATA_W-2:0], 1'b0};
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               out_data_q  <= DATA_W'(res_d);
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed self-checking bench for mod_reduce_seq (DATA_W=64, MODULUS=17).
module tb_mod_reduce_seq;

   localparam int DATA_W = 64;
   localparam int MOD_W  = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
`ifdef MOD_RUNTIME_EN
   logic [MOD_W-1:0]  mod_in;
`endif

   int n_pass;
   int n_total;

   mod_reduce_seq #(
      .DATA_W  (DATA_W),
      .MOD_W   (MOD_W),
      .MODULUS (17)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef MOD_RUNTIME_EN
      .mod_in    (mod_in),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers in_data until accepted, then drops in_valid.
   task automatic accept(input logic [DATA_W-1:0] x);
      int n;
      in_data  = x;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (out_data !== 64'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] vin [6];
      logic [DATA_W-1:0] vexp[6];
      int lat;
      vin = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFDE, 64'd0,
              64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      // 2**63 = 9 (mod 17), so -2**63 gives 8 and 2**63-1 gives 8.
      vexp = '{64'd15, 64'd16, 64'd0, 64'd0, 64'd8, 64'd8};
      for (int i = 0; i < 6; i++) begin
         accept(vin[i]);
         wait_out(lat);
         n_total++;
         if (lat != 65) $display("FAIL basic_latency[%0d]: got %0d edges expected 65", i, lat);
         else n_pass++;
         n_total++;
         if (out_data !== vexp[i])
            $display("FAIL basic_value[%0d] in=%h: got %0d expected %0d", i, vin[i], out_data, vexp[i]);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      accept(64'd100);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_data !== 64'd15 || in_ready !== 1'b0)
            $display("FAIL hold[%0d]: got valid=%b data=%0d ready=%b expected valid=1 data=15 ready=0",
                     i, out_valid, out_data, in_ready);
         else n_pass++;
         tick();
      end
      consume();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      accept(64'd100);
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0)
         $display("FAIL abort: got valid=%b ready=%b data=%0d expected valid=0 ready=1 data=0",
                  out_valid, in_ready, out_data);
      else n_pass++;
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      n_total++;
      if (seen) $display("FAIL stale_result: got out_valid=1 expected 0 after abort");
      else n_pass++;
      accept(64'd35);
      wait_out(lat);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 64'd1)
         $display("FAIL after_abort: got valid=%b data=%0d expected valid=1 data=1", out_valid, out_data);
      else n_pass++;
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      int n;
      in_data  = 64'd18;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      tick();
      in_data = 64'hFFFF_FFFF_FFFF_FFEE;
      wait_out(lat);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 64'd1 || in_ready !== 1'b0)
         $display("FAIL b2b_first: got valid=%b data=%0d ready=%b expected valid=1 data=1 ready=0",
                  out_valid, out_data, in_ready);
      else n_pass++;
      consume();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL b2b_gap: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL b2b_accept2: got ready=%b expected 0", in_ready);
      else n_pass++;
      wait_out(lat);
      n_total++;
      if (lat != 65 || out_data !== 64'd16)
         $display("FAIL b2b_second: got lat=%0d data=%0d expected lat=65 data=16", lat, out_data);
      else n_pass++;
      consume();
   endtask

`ifdef MOD_RUNTIME_EN
   task automatic test_runtime_mod();
      int lat;
      mod_in = 8'd7;
      in_data  = 64'hFFFF_FFFF_FFFF_FFF1;
      in_valid = 1'b1;
      while (!in_ready) tick();
      tick();
      in_valid = 1'b0;
      mod_in   = 8'd5;
      wait_out(lat);
      n_total++;
      if (out_data !== 64'd6) $display("FAIL rt_mod7: got %0d expected 6", out_data);
      else n_pass++;
      consume();
      mod_in = 8'd0;
      accept(64'd100);
      wait_out(lat);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 64'd0)
         $display("FAIL rt_mod0: got valid=%b data=%0d expected valid=1 data=0", out_valid, out_data);
      else n_pass++;
      consume();
      mod_in = 8'd1;
      accept(64'd100);
      wait_out(lat);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 64'd0)
         $display("FAIL rt_mod1: got valid=%b data=%0d expected valid=1 data=0", out_valid, out_data);
      else n_pass++;
      consume();
      mod_in = 8'd17;
   endtask
`endif

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef MOD_RUNTIME_EN
      mod_in    = 8'd17;
`endif
      #12;
      test_reset();
      tick();
      rst = 1'b0;
      tick();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef MOD_RUNTIME_EN
      test_runtime_mod();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
